// File: rtl/sls_serial_sub_v.sv
// Bit-serial ripple subtractor: diff = x - y - bin, one bit per clock, LSB first.
// One full-subtractor cell plus a borrow flip-flop. Operands load on start and the
// parallel result is flagged by a single-cycle done pulse.
// Optional build macro SLS_SERIAL_ADDSUB_EN adds an add_n port that turns the cell
// into a full adder (bin becomes carry-in, bout becomes carry-out).
module sls_serial_sub_v #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  input  logic             bin,
`ifdef SLS_SERIAL_ADDSUB_EN
  input  logic             add_n,
`endif
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] xr_q, yr_q, diff_q;
  logic             br_q, xs_q, ys_q;
  logic [CntW-1:0]  cnt_q;
  logic             bout_q, ovf_q, busy_q, done_q;
`ifdef SLS_SERIAL_ADDSUB_EN
  logic             add_q;
`endif

  logic             d_bit, b_next, ovf_next;
  logic [WIDTH-1:0] diff_shift;

  // Single arithmetic cell operating on the current LSBs, plus the result shifter.
  always_comb begin
    d_bit    = xr_q[0] ^ yr_q[0] ^ br_q;
    b_next   = (~xr_q[0] & yr_q[0]) | (~(xr_q[0] ^ yr_q[0]) & br_q);
    ovf_next = (xs_q != ys_q) && (d_bit != xs_q);
`ifdef SLS_SERIAL_ADDSUB_EN
    if (add_q) begin
      b_next   = (xr_q[0] & yr_q[0]) | (br_q & (xr_q[0] ^ yr_q[0]));
      ovf_next = (xs_q == ys_q) && (d_bit != xs_q);
    end
`endif
    // Written as shift-then-insert so WIDTH=1 needs no special case.
    diff_shift            = diff_q >> 1;
    diff_shift[WIDTH-1]   = d_bit;
  end

  // Control FSM and datapath registers; all outputs are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      xr_q    <= '0;
      yr_q    <= '0;
      br_q    <= 1'b0;
      xs_q    <= 1'b0;
      ys_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SLS_SERIAL_ADDSUB_EN
      add_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (start) begin
            xr_q    <= x_in;
            yr_q    <= y_in;
            br_q    <= bin;
            xs_q    <= x_in[WIDTH-1];
            ys_q    <= y_in[WIDTH-1];
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StShift;
`ifdef SLS_SERIAL_ADDSUB_EN
            add_q   <= add_n;
`endif
          end
        end
        StShift: begin
          diff_q <= diff_shift;
          xr_q   <= xr_q >> 1;
          yr_q   <= yr_q >> 1;
          br_q   <= b_next;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
            bout_q  <= b_next;
            ovf_q   <= ovf_next;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_sls_serial_sub_v.sv
// Scoreboard bench for sls_serial_sub_v at WIDTH=8 and WIDTH=1. Expected results
// come from integer arithmetic on the operands; monitors pop them on each done pulse.
module tb_sls_serial_sub_v;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       s8 = 1'b0, b8 = 1'b0, add8 = 1'b0;
  logic [7:0] x8 = '0, y8 = '0, d8;
  logic       bo8, ov8, busy8, done8;
  // WIDTH=1 instance
  logic       s1 = 1'b0, b1 = 1'b0, add1 = 1'b0;
  logic [0:0] x1 = '0, y1 = '0, d1;
  logic       bo1, ov1, busy1, done1;

  sls_serial_sub_v #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(s8), .x_in(x8), .y_in(y8), .bin(b8),
`ifdef SLS_SERIAL_ADDSUB_EN
    .add_n(add8),
`endif
    .diff(d8), .bout(bo8), .ovf(ov8), .busy(busy8), .done(done8)
  );

  sls_serial_sub_v #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(s1), .x_in(x1), .y_in(y1), .bin(b1),
`ifdef SLS_SERIAL_ADDSUB_EN
    .add_n(add1),
`endif
    .diff(d1), .bout(bo1), .ovf(ov1), .busy(busy1), .done(done1)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [33:0] q8[$];
  logic [33:0] q1[$];
  logic pd8 = 1'b0, pd1 = 1'b0;

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: {ovf, bout, result} from plain signed/unsigned integer arithmetic.
  function automatic logic [33:0] model(input int w, input longint x, input longint y,
                                        input longint b, input bit add);
    longint m, half, sx, sy, r, sr;
    bit c, o;
    m    = longint'(1) << w;
    half = m >> 1;
    sx   = (x >= half) ? x - m : x;
    sy   = (y >= half) ? y - m : y;
    if (add) begin
      r  = x + y + b;
      c  = (r >= m);
      sr = sx + sy + b;
    end else begin
      r  = x - y - b;
      c  = (x < y + b);
      sr = sx - sy - b;
    end
    o = (sr < -half) || (sr > half - 1);
    return {o, c, 32'(r & (m - 1))};
  endfunction

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin
    pd8 <= done8;
    if (done8) begin
      logic [33:0] e;
      check("done8 pulse width", {33'd0, pd8}, 34'd0);
      check("done8 expected", {33'd0, q8.size() > 0}, 34'd1);
      if (q8.size() > 0) begin
        e = q8.pop_front();
        check("diff8", {26'd0, d8}, {26'd0, e[7:0]});
        check("bout8", {33'd0, bo8}, {33'd0, e[32]});
        check("ovf8", {33'd0, ov8}, {33'd0, e[33]});
      end
    end
  end

  // Monitor for the 1-bit instance.
  always @(negedge clk) begin
    pd1 <= done1;
    if (done1) begin
      logic [33:0] e;
      check("done1 pulse width", {33'd0, pd1}, 34'd0);
      check("done1 expected", {33'd0, q1.size() > 0}, 34'd1);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check("diff1", {33'd0, d1}, {33'd0, e[0]});
        check("bout1", {33'd0, bo1}, {33'd0, e[32]});
        check("ovf1", {33'd0, ov1}, {33'd0, e[33]});
      end
    end
  end

  // Issue one 8-bit operation from a negedge; returns at the negedge showing done.
  // glitch_k / rst_k pulse start or rst at that busy cycle (0 = never).
  task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic b,
                     input logic add, input int glitch_k, input int rst_k);
    int k;
    int busy_cnt;
    x8 = x; y8 = y; b8 = b; add8 = add; s8 = 1'b1;
    q8.push_back(model(8, longint'(x), longint'(y), longint'(b), add));
    @(negedge clk);
    s8 = 1'b0;
    k = 1;
    busy_cnt = 0;
    check("busy8 after start", {33'd0, busy8}, 34'd1);
    while (!done8 && k < 20) begin
      if (busy8) busy_cnt++;
      if (k == rst_k) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst busy8", {33'd0, busy8}, 34'd0);
        check("rst done8", {33'd0, done8}, 34'd0);
        check("rst diff8", {26'd0, d8}, 34'd0);
        check("rst bout8", {33'd0, bo8}, 34'd0);
        check("rst ovf8", {33'd0, ov8}, 34'd0);
        q8.delete();
        repeat (12) @(negedge clk);
        return;
      end
      // Inputs are don't-care while shifting; scramble them.
      x8 = 8'($urandom); y8 = 8'($urandom); b8 = 1'($urandom); add8 = 1'($urandom);
      s8 = (k == glitch_k);
      if (k == glitch_k) begin
        x8 = 8'hFF; y8 = 8'h00;
      end
      @(negedge clk);
      s8 = 1'b0;
      k++;
    end
    check("done8 latency", 34'(k), 34'd9);
    check("busy8 cycles", 34'(busy_cnt), 34'd8);
    check("busy8 in done cycle", {33'd0, busy8}, 34'd0);
  endtask

  task automatic op1(input logic x, input logic y, input logic b, input logic add);
    int k;
    x1 = x; y1 = y; b1 = b; add1 = add; s1 = 1'b1;
    q1.push_back(model(1, longint'(x), longint'(y), longint'(b), add));
    @(negedge clk);
    s1 = 1'b0;
    k = 1;
    check("busy1 after start", {33'd0, busy1}, 34'd1);
    while (!done1 && k < 10) begin
      x1 = 1'($urandom); y1 = 1'($urandom); b1 = 1'($urandom);
      @(negedge clk);
      k++;
    end
    check("done1 latency", 34'(k), 34'd2);
  endtask

  initial begin
    logic [2:0] combo;
    logic       add_r;
    repeat (3) @(negedge clk);
    check("reset diff", {26'd0, d8}, 34'd0);
    check("reset bout", {33'd0, bo8}, 34'd0);
    check("reset ovf", {33'd0, ov8}, 34'd0);
    check("reset busy", {33'd0, busy8}, 34'd0);
    check("reset done", {33'd0, done8}, 34'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases; each call starts in the previous done cycle (back-to-back).
    op8(8'h05, 8'h03, 1'b0, 1'b0, 0, 0);
    op8(8'h03, 8'h05, 1'b0, 1'b0, 0, 0);
    op8(8'h00, 8'h00, 1'b1, 1'b0, 0, 0);
    op8(8'h80, 8'h01, 1'b0, 1'b0, 0, 0);
    op8(8'h7F, 8'hFF, 1'b0, 1'b0, 0, 0);
    op8(8'h12, 8'h34, 1'b1, 1'b0, 3, 0);
    op8(8'h55, 8'h0F, 1'b0, 1'b0, 0, 4);
    check("post-reset no pending", 34'(q8.size()), 34'd0);
`ifdef SLS_SERIAL_ADDSUB_EN
    op8(8'hFF, 8'h01, 1'b0, 1'b1, 0, 0);
`endif

    for (int i = 0; i < 24; i++) begin
      add_r = 1'b0;
`ifdef SLS_SERIAL_ADDSUB_EN
      add_r = 1'($urandom);
`endif
      op8(8'($urandom), 8'($urandom), 1'($urandom), add_r, 0, 0);
    end

    // WIDTH=1: full truth table of {bin, x, y}, then a few more.
    for (int i = 0; i < 8; i++) begin
      combo = 3'(i);
      op1(combo[1], combo[0], combo[2], 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      add_r = 1'b0;
`ifdef SLS_SERIAL_ADDSUB_EN
      add_r = 1'($urandom);
`endif
      op1(1'($urandom), 1'($urandom), 1'($urandom), add_r);
    end

    repeat (4) @(negedge clk);
    check("queue8 drained", 34'(q8.size()), 34'd0);
    check("queue1 drained", 34'(q1.size()), 34'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sls_serial_sub_v.md
Name: sls_serial_sub_v

Overview:
- Bit-serial ripple subtractor computing diff = x - y - bin over WIDTH cycles.
- Uses one full-subtractor cell (the inverse of the full-adder cell) plus a borrow flip-flop.
- Sits beside the combinational adder labs as the sequential, area-minimal counterpart.
- Operands are loaded in parallel on a start strobe. The result is presented in parallel with a one-cycle done pulse.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  load request; sampled only when busy=0.
- x_in  input  WIDTH  minuend.
- y_in  input  WIDTH  subtrahend.
- bin  input  1  borrow-in.
- diff  output  WIDTH  difference; valid while done=1 and held until the next accepted start.
- bout  output  1  borrow-out of the MSB stage.
- ovf  output  1  two's-complement overflow.
- busy  output  1  high while shifting.
- done  output  1  one-cycle pulse when the result is final.

Behaviour:
- Reset (synchronous, active-high, evaluated at a rising edge of clk):
  - State goes to IDLE.
  - diff=0, bout=0, ovf=0, busy=0, done=0, bit counter=0.
  - Shift registers are cleared.
- FSM has two states: IDLE and SHIFT.
- IDLE:
  - On an edge with start=1: load xr<=x_in, yr<=y_in, br<=bin, capture xs<=x_in[WIDTH-1] and ys<=y_in[WIDTH-1], cnt<=0, busy<=1, done<=0, then go to SHIFT.
  - On an edge with start=0: stay in IDLE; done<=0.
- SHIFT, at each edge:
  - d = xr[0]^yr[0]^br
  - b' = (~xr[0]&yr[0]) | (~(xr[0]^yr[0])&br)
  - diff<={d,diff[WIDTH-1:1]}; xr and yr shift right by 1; br<=b'; cnt<=cnt+1.
- On the edge where cnt==WIDTH-1:
  - Shift the last bit.
  - bout<=b'.
  - ovf<=(xs!=ys)&&(d!=xs).
  - busy<=0, done<=1, next state IDLE.
- Latency: with the start edge as E0, the bits are processed at E1..EWIDTH. done is high for exactly the cycle after EWIDTH. A new start is accepted from that cycle onward, including the cycle where done=1.
- During SHIFT:
  - start is ignored.
  - x_in, y_in and bin may change freely with no effect.
- diff, bout and ovf hold their values between operations.
- During SHIFT, diff holds partial values and bout/ovf hold the previous operation's values; consumers use done only.
- Reset asserted mid-SHIFT:
  - The operation is abandoned with no done pulse.
  - All outputs go to their reset values at that edge.
- If rst and start are both high on the same edge, rst wins.
- cnt is $clog2(WIDTH) bits wide, minimum 1 bit. WIDTH=1 gives exactly one SHIFT edge.
- Arithmetic is modulo 2^WIDTH. bout=1 exactly when x_in < y_in+bin (unsigned comparison).

Optional Feature:
- Macro: SLS_SERIAL_ADDSUB_EN.
- When defined:
  - Extra port add_n (input, 1 bit), sampled at the start edge together with the operands.
  - add_n=1: the cell becomes a full adder. sum=xr[0]^yr[0]^br, carry'=(xr[0]&yr[0])|(br&(xr[0]^yr[0])).
  - bin acts as carry-in and bout reports carry-out.
  - ovf=(xs==ys)&&(d!=xs).
  - add_n=0 gives the subtract behaviour above.
- When not defined:
  - No add_n port; the block is subtract-only.
  - Timing is identical in both builds.

Test Plan:
- WIDTH=8, x=0x05, y=0x03, bin=0, start for 1 cycle -> busy=1 for 8 cycles; done=1 in the 9th cycle after the start edge; diff=0x02, bout=0, ovf=0.
- WIDTH=8, x=0x03, y=0x05, bin=0 -> diff=0xFE, bout=1, ovf=0. Then x=0x00, y=0x00, bin=1 -> diff=0xFF, bout=1.
- WIDTH=8, x=0x80, y=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1. Then x=0x7F, y=0xFF -> diff=0x80, bout=1, ovf=1.
- WIDTH=1, all 8 combinations of {bin,x,y}, e.g. 000->diff 0/bout 0, 001->1/1, 010->1/0, 011->0/0, 100->1/1, 101->0/1, 110->0/0, 111->1/1 -> each matches the full-subtractor truth table, with done one cycle after the start edge.
- WIDTH=8:
  - Pulse start again at the 3rd busy cycle with x=0xFF, y=0x00 -> ignored; the original result is delivered with a single done pulse.
  - Start again in the done cycle -> accepted, busy=1 in the next cycle.
- WIDTH=8, rst=1 at the 4th busy cycle -> next cycle shows busy=0, done=0, diff=0x00, bout=0, ovf=0, and no done pulse follows. With SLS_SERIAL_ADDSUB_EN: add_n=1, 0xFF+0x01 -> diff=0x00, bout=1, ovf=0.
